block_sync_rx_64b66b: RTL and testbench
=======================================

BLOCK_SYNC_RX_64B66B -- requirements
Module: block_sync_rx_64b66b

Interface
REQ-001 The block SHALL have parameter LOCK_CNT, default 64, meaning consecutive valid sync headers needed to acquire lock and the size of the locked-state monitoring window.
REQ-002 The block SHALL have parameter BAD_CNT, default 16, meaning invalid headers within one window that force loss of lock.
REQ-003 The block SHALL have parameter SLIP_WAIT, default 4, meaning clock cycles during which headers are ignored after each slip.
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port nreset, input, 1, meaning reset, asynchronous, active-low.
REQ-006 The block SHALL have port valid_i, input, 1, meaning head_i carries the sync header of one 66b block this cycle.
REQ-007 The block SHALL have port head_i, input, 2, meaning the received 2-bit sync header.
REQ-008 The block SHALL have port lock_o, output, 1, meaning block lock is achieved; the descrambler consumes data only while it is high.
REQ-009 The block SHALL have port slip_o, output, 1, meaning a one-cycle request to the RX gearbox to shift block alignment by one bit.

Function
REQ-010 A header SHALL be valid iff head_i is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
REQ-011 The FSM SHALL have exactly three states: UNLOCK, LOCK and SLIP_W.
REQ-012 Headers SHALL be evaluated only when valid_i=1 and state is not SLIP_W; in all other cycles counters hold.
REQ-013 The good counter SHALL count 0..LOCK_CNT and the bad counter 0..BAD_CNT, each $clog2(max+1) bits wide; neither SHALL wrap.
REQ-014 In UNLOCK, a valid header SHALL increment the good counter; the evaluation that makes it LOCK_CNT SHALL set lock_o=1 on that edge, clear both counters and enter LOCK.
REQ-015 In UNLOCK, an invalid header SHALL clear the good counter, pulse slip_o for one cycle on that edge and enter SLIP_W.
REQ-016 In LOCK, every evaluated header SHALL increment the window counter and every invalid header SHALL also increment the bad counter.
REQ-017 In LOCK, the evaluation that makes the bad counter reach BAD_CNT SHALL, on that edge, set lock_o=0, pulse slip_o, clear both counters and enter SLIP_W; this takes priority over window completion in the same evaluation.
REQ-018 In LOCK, the evaluation that makes the window counter reach LOCK_CNT with the bad counter below BAD_CNT SHALL clear both counters and keep lock_o=1.
REQ-019 SLIP_W SHALL last exactly SLIP_W_AIT... 
REQ-019 SLIP_W SHALL last exactly SLIP_WAIT cycles regardless of valid_i, then enter UNLOCK with both counters at zero.
REQ-020 slip_o SHALL be high for exactly one cycle per slip; two slip pulses SHALL be at least SLIP_WAIT+1 cycles apart.
REQ-021 lock_o and slip_o SHALL be registered outputs with no combinational path from inputs.
REQ-022 Latency SHALL be one edge: the output reacting to a header changes at the edge that samples that header.
REQ-023 In UNLOCK, valid_i=0 cycles between valid headers SHALL neither break the consecutive count nor advance it.

Reset
REQ-024 When nreset=0, the block SHALL immediately force state UNLOCK, both counters 0, lock_o=0 and slip_o=0.
REQ-025 Reset asserted in any state, including mid-SLIP_W or mid-window, SHALL discard all progress; after release, lock requires a full LOCK_CNT valid headers.
REQ-026 The first evaluation SHALL occur on the first rising edge after nreset deasserts.

Verification
REQ-027 Reset release, then 64 beats of head_i=2'b01 with valid_i=1 -> lock_o rises at the edge sampling the 64th beat; slip_o stays 0.
REQ-028 Unlocked, 30 valid headers then head_i=2'b11 -> slip_o high exactly one cycle, lock_o=0, next 4 cycles ignored, then 64 more valid headers needed for lock.
REQ-029 Locked, 15 invalid headers in one 64-beat window -> lock_o stays 1; the window restarts with the bad counter at 0.
REQ-030 Locked, the 16th invalid header within a window -> lock_o falls and slip_o pulses on the same edge; then SLIP_W for 4 cycles.
REQ-031 Locked, the 16th invalid header is also the 64th beat of the window -> loss of lock and slip (priority check).
REQ-032 Valid headers with valid_i toggling 1/0, the pattern of a 32-bit datapath, -> lock after 64 valid beats (127 cycles); nreset pulsed mid-window -> lock_o=0 immediately and the count restarts.

Source files
------------

// File: rtl/block_sync_rx_64b66b.sv
// 64b/66b receive block synchroniser: hunts for sync-header alignment,
// asks the gearbox to slip on a bad header, and monitors lock in windows.
module block_sync_rx_64b66b #(
    parameter int LOCK_CNT  = 64,
    parameter int BAD_CNT   = 16,
    parameter int SLIP_WAIT = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       valid_i,
    input  logic [1:0] head_i,
    output logic       lock_o,
    output logic       slip_o
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(BAD_CNT + 1);
    localparam int WW = $clog2(SLIP_WAIT + 1);

    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
    localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_CNT - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        UNLOCK = 2'd0,
        LOCK   = 2'd1,
        SLIP_W = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [GW-1:0] good_cnt, good_nxt;
    logic [BW-1:0] bad_cnt, bad_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;
    logic          lock_nxt, slip_nxt;

    logic eval, hdr_ok, good_last, bad_hit, wait_done;

    // Header qualification shared by both combinational processes.
    // A legal header is 01 or 10; the window counter reuses good_cnt.
    always_comb begin
        eval      = valid_i && (state != SLIP_W);
        hdr_ok    = head_i[1] ^ head_i[0];
        good_last = (good_cnt == GOOD_LAST);
        bad_hit   = !hdr_ok && (bad_cnt == BAD_LAST);
        wait_done = (wait_cnt == WAIT_LAST);
    end

    // State, counters and both outputs are registered.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= UNLOCK;
            good_cnt <= '0;
            bad_cnt  <= '0;
            wait_cnt <= '0;
            lock_o   <= 1'b0;
            slip_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            bad_cnt  <= bad_nxt;
            wait_cnt <= wait_nxt;
            lock_o   <= lock_nxt;
            slip_o   <= slip_nxt;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt = state;
        unique case (state)
            UNLOCK: begin
                if (eval && !hdr_ok)
                    state_nxt = SLIP_W;
                else if (eval && good_last)
                    state_nxt = LOCK;
            end
            LOCK: begin
                if (eval && bad_hit)
                    state_nxt = SLIP_W;
            end
            SLIP_W: begin
                if (wait_done)
                    state_nxt = UNLOCK;
            end
            default: state_nxt = UNLOCK;
        endcase
    end

    // Counter updates and next values of the registered outputs.
    always_comb begin
        good_nxt = good_cnt;
        bad_nxt  = bad_cnt;
        wait_nxt = wait_cnt;
        lock_nxt = lock_o;
        slip_nxt = 1'b0;
        unique case (state)
            UNLOCK: begin
                if (eval) begin
                    if (!hdr_ok) begin
                        good_nxt = '0;
                        wait_nxt = '0;
                        slip_nxt = 1'b1;
                    end else if (good_last) begin
                        good_nxt = '0;
                        bad_nxt  = '0;
                        lock_nxt = 1'b1;
                    end else begin
                        good_nxt = good_cnt + GW'(1);
                    end
                end
            end
            LOCK: begin
                if (eval) begin
                    if (bad_hit) begin
                        good_nxt = '0;
                        bad_nxt  = '0;
                        wait_nxt = '0;
                        lock_nxt = 1'b0;
                        slip_nxt = 1'b1;
                    end else if (good_last) begin
                        good_nxt = '0;
                        bad_nxt  = '0;
                    end else begin
                        good_nxt = good_cnt + GW'(1);
                        if (!hdr_ok)
                            bad_nxt = bad_cnt + BW'(1);
                    end
                end
            end
            SLIP_W: begin
                if (wait_done) begin
                    good_nxt = '0;
                    bad_nxt  = '0;
                    wait_nxt = '0;
                end else begin
                    wait_nxt = wait_cnt + WW'(1);
                end
            end
            default: begin
                good_nxt = '0;
                bad_nxt  = '0;
                wait_nxt = '0;
                lock_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_block_sync_rx_64b66b.sv
// Bench for block_sync_rx_64b66b: directed scenarios plus random
// headers, checked every cycle against a beat-level behavioural model.
module tb_block_sync_rx_64b66b;

    localparam int LOCK_CNT  = 64;
    localparam int BAD_CNT   = 16;
    localparam int SLIP_WAIT = 4;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       valid = 1'b0;
    logic [1:0] head = 2'b00;
    logic       lock;
    logic       slip;

    int n_vec = 0;
    int n_err = 0;
    string phase = "init";

    // Model: lock flag, run length, window position, bad count,
    // and the number of beats still to be ignored after a slip.
    bit m_lock, m_slip;
    int run_len, win_pos, bad_seen, ignore_left;

    block_sync_rx_64b66b #(
        .LOCK_CNT (LOCK_CNT),
        .BAD_CNT  (BAD_CNT),
        .SLIP_WAIT(SLIP_WAIT)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .valid_i(valid),
        .head_i (head),
        .lock_o (lock),
        .slip_o (slip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s/%s got %b want %b at %0t",
                     phase, tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_lock = 0;
        m_slip = 0;
        run_len = 0;
        win_pos = 0;
        bad_seen = 0;
        ignore_left = 0;
    endtask

    task automatic start_slip();
        m_slip = 1;
        m_lock = 0;
        run_len = 0;
        win_pos = 0;
        bad_seen = 0;
        ignore_left = SLIP_WAIT;
    endtask

    task automatic model_beat(input logic v, input logic [1:0] h);
        bit good;
        good = (h == 2'b01) || (h == 2'b10);
        m_slip = 0;
        if (ignore_left > 0) begin
            ignore_left--;
        end else if (v) begin
            if (!m_lock) begin
                if (!good) begin
                    start_slip();
                end else begin
                    run_len++;
                    if (run_len == LOCK_CNT) begin
                        m_lock = 1;
                        run_len = 0;
                        win_pos = 0;
                        bad_seen = 0;
                    end
                end
            end else begin
                win_pos++;
                if (!good) bad_seen++;
                if (bad_seen == BAD_CNT) begin
                    start_slip();
                end else if (win_pos == LOCK_CNT) begin
                    win_pos = 0;
                    bad_seen = 0;
                end
            end
        end
    endtask

    task automatic beat(input logic v, input logic [1:0] h);
        valid = v;
        head = h;
        @(posedge clk);
        model_beat(v, h);
        #1;
        check("lock", lock, m_lock);
        check("slip", slip, m_slip);
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        #1;
        model_clear();
        check("rst_lock", lock, 1'b0);
        check("rst_slip", slip, 1'b0);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    function automatic logic [1:0] pick(input int bad_pct);
        logic [1:0] g;
        logic [1:0] b;
        g = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
        b = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
        return ($urandom_range(0, 99) < bad_pct) ? b : g;
    endfunction

    initial begin
        int rates[4];
        rates = '{0, 2, 8, 30};
        model_clear();

        phase = "reset";
        #12;
        do_reset();

        phase = "acquire";
        for (int i = 0; i < LOCK_CNT - 1; i++)
            beat(1'b1, 2'b01);
        check("pre_lock", lock, 1'b0);
        beat(1'b1, 2'b01);
        check("lock_at_64", lock, 1'b1);

        phase = "bad15";
        for (int i = 0; i < LOCK_CNT; i++)
            beat(1'b1, (i < BAD_CNT - 1) ? 2'b11 : 2'b10);
        for (int i = 0; i < BAD_CNT - 1; i++)
            beat(1'b1, 2'b00);
        check("hold_lock", lock, 1'b1);

        phase = "bad16";
        beat(1'b1, 2'b11);
        check("lost", lock, 1'b0);
        check("slip_pulse", slip, 1'b1);
        for (int i = 0; i < SLIP_WAIT; i++)
            beat(1'b1, 2'b00);
        check("no_reslip", slip, 1'b0);

        phase = "priority";
        for (int i = 0; i < LOCK_CNT; i++)
            beat(1'b1, 2'b01);
        for (int i = 0; i < LOCK_CNT - BAD_CNT; i++)
            beat(1'b1, 2'b10);
        for (int i = 0; i < BAD_CNT; i++)
            beat(1'b1, 2'b11);
        check("prio_lost", lock, 1'b0);
        check("prio_slip", slip, 1'b1);

        phase = "unlock_slip";
        for (int i = 0; i < SLIP_WAIT; i++)
            beat($urandom_range(0, 1) == 1, 2'b11);
        for (int i = 0; i < 30; i++)
            beat(1'b1, 2'b01);
        beat(1'b1, 2'b11);
        check("u_slip", slip, 1'b1);
        for (int i = 0; i < SLIP_WAIT + LOCK_CNT; i++)
            beat(1'b1, 2'b10);
        check("relock", lock, 1'b1);

        phase = "toggle";
        do_reset();
        for (int i = 0; i < 2 * LOCK_CNT - 1; i++)
            beat(i % 2 == 0, 2'b01);
        check("lock_127", lock, 1'b1);

        phase = "mid_reset";
        for (int i = 0; i < 20; i++)
            beat(1'b1, 2'b01);
        do_reset();
        for (int i = 0; i < LOCK_CNT - 1; i++)
            beat(1'b1, 2'b10);
        check("restart", lock, 1'b0);
        beat(1'b1, 2'b10);
        check("relock2", lock, 1'b1);

        phase = "random";
        for (int s = 0; s < 24; s++) begin
            int r;
            r = rates[$urandom_range(0, 3)];
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 999) == 0)
                    do_reset();
                beat($urandom_range(0, 9) < 8, pick(r));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
